// File: rtl/guess_lock_pkg.sv
// Shared types for the guess/lock engine: FSM state codes, segment glyphs
// and the hex-to-segment decoder (active-low {dp,g..a}).
package guess_lock_pkg;

    typedef enum logic [2:0] {
        S_P1     = 3'd0,
        S_SECRET = 3'd1,
        S_P2     = 3'd2,
        S_GUESS  = 3'd3,
        S_LO     = 3'd4,
        S_HI     = 3'd5,
        S_WIN    = 3'd6,
        S_LOCK   = 3'd7
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_P     = 8'h8C;
    localparam logic [7:0] SEG_L     = 8'hC7;
    localparam logic [7:0] SEG_H     = 8'h89;
    localparam logic [7:0] SEG_I     = 8'hCF;
    localparam logic [7:0] SEG_O     = 8'hC0;
    localparam logic [7:0] LEDS_LOCK = 8'hAA;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] v);
        logic [7:0] seg;
        case (v)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/guess_lock_core_if.sv
// Player controls and board outputs of the guess/lock engine.
interface guess_lock_core_if #(
    parameter int NUM_DIGITS = 4
);
    logic [NUM_DIGITS-1:0] digit_sel;
    logic [3:0]            buttons;
    logic                  commit;
    logic                  retry;
    logic                  new_game;
    logic [7:0]            leds;
    logic [7:0]            cathods;
    logic [NUM_DIGITS-1:0] anodes;
    logic [2:0]            state_o;
    logic [7:0]            attempts_o;

    modport master (
        output digit_sel, buttons, commit, retry, new_game,
        input  leds, cathods, anodes, state_o, attempts_o
    );

    modport slave (
        input  digit_sel, buttons, commit, retry, new_game,
        output leds, cathods, anodes, state_o, attempts_o
    );
endinterface

// File: rtl/guess_lock_core_seg_scan.sv
// Multiplexed 7-segment scanner: walks one low anode across the digits and
// registers the matching glyph in the same cycle so anode and segments never skew.
module seg_scan #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1500
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_DIGITS*8-1:0] glyphs,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic [7:0]              cathods
);
    localparam int CNT_W = $clog2(SCAN_DIV + 1);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CNT_W-1:0] cnt_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [IDX_W-1:0] idx_next;
    logic             wrap;

    assign wrap     = (cnt_reg == CNT_W'(SCAN_DIV - 1));
    assign idx_next = !wrap ? idx_reg :
                      (idx_reg == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_reg <= '0;
            idx_reg <= '0;
            anodes  <= ~NUM_DIGITS'(1);
            cathods <= glyphs[7:0];
        end else begin
            cnt_reg <= wrap ? '0 : cnt_reg + CNT_W'(1);
            idx_reg <= idx_next;
            anodes  <= ~(NUM_DIGITS'(1) << idx_next);
            // Refreshed every cycle so a glyph change shows without waiting for the next digit.
            cathods <= glyphs[{idx_next, 3'b000} +: 8];
        end
    end
endmodule

// File: rtl/guess_lock_core.sv
// Two-player guess/lock engine: secret entry, guessing with LO/HI/WIN feedback,
// attempt-limited lockout, LED bank and glyph buffer feeding the display scanner.
module guess_lock_core
    import guess_lock_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_W      = 4,
    parameter int MAX_ATTEMPTS = 15,
    parameter int SCAN_DIV     = 1500,
    parameter int BLINK_DIV    = 10000000,
    parameter int LOCK_CYCLES  = 50000000
) (
    input logic               clock,
    input logic               reset,
    guess_lock_core_if.slave  bus
);
    localparam int LOCK_W  = $clog2(LOCK_CYCLES + 1);
    localparam int BLINK_W = $clog2(BLINK_DIV + 1);
    localparam int CODE_W  = NUM_DIGITS * DIGIT_W;

    state_t               state_reg;
    logic [DIGIT_W-1:0]   entry_reg  [NUM_DIGITS];
    logic [DIGIT_W-1:0]   secret_reg [NUM_DIGITS];
    logic [7:0]           attempts_reg;
    logic [7:0]           leds_reg;
    logic [BLINK_W-1:0]   blink_cnt_reg;
    logic [LOCK_W-1:0]    lock_cnt_reg;

    logic [3:0]           buttons_prev_reg;
    logic                 commit_prev_reg;
    logic                 retry_prev_reg;
    logic                 new_game_prev_reg;

    logic                 btn_edge, commit_edge, retry_edge, new_game_edge;
    logic                 sel_onehot;
    logic [7:0]           attempts_next;
    logic [CODE_W-1:0]    entry_flat, secret_flat;
    logic [NUM_DIGITS*8-1:0] glyph_buf;

    always_ff @(posedge clock) begin
        if (reset) begin
            buttons_prev_reg  <= '0;
            commit_prev_reg   <= 1'b0;
            retry_prev_reg    <= 1'b0;
            new_game_prev_reg <= 1'b0;
        end else begin
            buttons_prev_reg  <= bus.buttons;
            commit_prev_reg   <= bus.commit;
            retry_prev_reg    <= bus.retry;
            new_game_prev_reg <= bus.new_game;
        end
    end

    assign btn_edge      = |(bus.buttons & ~buttons_prev_reg);
    assign commit_edge   = bus.commit & ~commit_prev_reg;
    assign retry_edge    = bus.retry & ~retry_prev_reg;
    assign new_game_edge = bus.new_game & ~new_game_prev_reg;
    assign sel_onehot    = (bus.digit_sel != '0) &&
                           ((bus.digit_sel & (bus.digit_sel - NUM_DIGITS'(1))) == '0);
    assign attempts_next = (attempts_reg == 8'hFF) ? 8'hFF : attempts_reg + 8'd1;

    // Digit 0 lands in the MSBs so a plain magnitude compare is lexicographic.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_flat
        assign entry_flat[(NUM_DIGITS-1-gi)*DIGIT_W +: DIGIT_W]  = entry_reg[gi];
        assign secret_flat[(NUM_DIGITS-1-gi)*DIGIT_W +: DIGIT_W] = secret_reg[gi];
    end

    always_ff @(posedge clock) begin
        if (reset || new_game_edge) begin
            state_reg     <= S_P1;
            attempts_reg  <= '0;
            leds_reg      <= '0;
            blink_cnt_reg <= '0;
            lock_cnt_reg  <= '0;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                entry_reg[k]  <= '0;
                secret_reg[k] <= '0;
            end
        end else begin
            case (state_reg)
                S_P1: if (btn_edge) begin
                    for (int k = 0; k < NUM_DIGITS; k++) entry_reg[k] <= '0;
                    state_reg <= S_SECRET;
                end
                S_SECRET: begin
                    if (commit_edge) begin
                        for (int k = 0; k < NUM_DIGITS; k++) begin
                            secret_reg[k] <= entry_reg[k];
                            entry_reg[k]  <= '0;
                        end
                        state_reg <= S_P2;
                    end else if (btn_edge && sel_onehot) begin
                        for (int k = 0; k < NUM_DIGITS; k++)
                            if (bus.digit_sel[k]) entry_reg[k] <= entry_reg[k] + DIGIT_W'(bus.buttons);
                    end
                end
                S_P2: if (btn_edge) state_reg <= S_GUESS;
                S_GUESS: begin
                    if (commit_edge) begin
                        if (entry_flat == secret_flat) begin
                            state_reg     <= S_WIN;
                            leds_reg      <= 8'hFF;
                            blink_cnt_reg <= '0;
                        end else begin
                            attempts_reg <= attempts_next;
                            if (attempts_next == 8'(MAX_ATTEMPTS)) begin
                                state_reg    <= S_LOCK;
                                leds_reg     <= LEDS_LOCK;
                                lock_cnt_reg <= LOCK_W'(LOCK_CYCLES - 1);
                            end else begin
                                state_reg <= (entry_flat < secret_flat) ? S_LO : S_HI;
                            end
                        end
                    end else if (btn_edge && sel_onehot) begin
                        for (int k = 0; k < NUM_DIGITS; k++)
                            if (bus.digit_sel[k]) entry_reg[k] <= entry_reg[k] + DIGIT_W'(bus.buttons);
                    end
                end
                S_LO, S_HI: if (retry_edge) state_reg <= S_GUESS;
                S_WIN: begin
                    if (blink_cnt_reg == BLINK_W'(BLINK_DIV - 1)) begin
                        blink_cnt_reg <= '0;
                        leds_reg      <= ~leds_reg;
                    end else begin
                        blink_cnt_reg <= blink_cnt_reg + BLINK_W'(1);
                    end
                end
                default: begin
                    // Lockout: only the timer (or new_game) gets the player out.
                    if (lock_cnt_reg == '0) begin
                        attempts_reg <= '0;
                        leds_reg     <= '0;
                        for (int k = 0; k < NUM_DIGITS; k++) entry_reg[k] <= '0;
                        state_reg <= S_P2;
                    end else begin
                        lock_cnt_reg <= lock_cnt_reg - LOCK_W'(1);
                    end
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_disp
        logic [7:0] glyph;
        always_comb begin
            glyph = SEG_BLANK;
            case (state_reg)
                S_P1, S_P2: begin
                    if (gi == 0)                   glyph = SEG_P;
                    else if (gi == NUM_DIGITS - 1) glyph = hex_to_seg((state_reg == S_P1) ? 4'h1 : 4'h2);
                    else if (gi == 1)              glyph = SEG_L;
                end
                S_SECRET, S_GUESS: glyph = hex_to_seg(4'(entry_reg[gi]));
                S_LO, S_HI: begin
                    if (gi == NUM_DIGITS - 3)      glyph = hex_to_seg(4'h2);
                    else if (gi == NUM_DIGITS - 2) glyph = (state_reg == S_LO) ? SEG_L : SEG_H;
                    else if (gi == NUM_DIGITS - 1) glyph = (state_reg == S_LO) ? SEG_O : SEG_I;
                end
                S_WIN: begin
                    if (gi == NUM_DIGITS - 2)      glyph = hex_to_seg(attempts_reg[7:4]);
                    else if (gi == NUM_DIGITS - 1) glyph = hex_to_seg(attempts_reg[3:0]);
                end
                default: glyph = SEG_DASH;
            endcase
        end
        assign glyph_buf[gi*8 +: 8] = glyph;
    end

    seg_scan #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV)
    ) u_scan (
        .clock   (clock),
        .reset   (reset),
        .glyphs  (glyph_buf),
        .anodes  (bus.anodes),
        .cathods (bus.cathods)
    );

    assign bus.leds       = leds_reg;
    assign bus.state_o    = state_reg;
    assign bus.attempts_o = attempts_reg;
endmodule

// File: tb/tb_guess_lock_core.sv
// Bench for guess_lock_core: vector table with a scoreboard of expected
// state/attempts/leds, plus hand sequences for scan, blink, lockout and hold.
module tb_guess_lock_core;
    import guess_lock_pkg::*;

    typedef struct {
        logic [3:0] btn;
        logic [3:0] sel;
        logic       commit;
        logic       retry;
        logic       ng;
        logic [2:0] st;
        logic [7:0] att;
        logic [7:0] leds;
    } vec_t;

    typedef struct {
        logic [2:0] st;
        logic [7:0] att;
        logic [7:0] leds;
    } exp_t;

    logic clock;
    logic reset;
    int   n_applied;
    int   n_miscompare;
    vec_t tbl[$];
    exp_t sb[$];
    int   p1_end, p2_end, p3_end;

    guess_lock_core_if #(.NUM_DIGITS(4)) bus ();

    guess_lock_core #(
        .NUM_DIGITS   (4),
        .DIGIT_W      (4),
        .MAX_ATTEMPTS (3),
        .SCAN_DIV     (3),
        .BLINK_DIV    (4),
        .LOCK_CYCLES  (10)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk_vec(input logic [3:0] btn, input logic [3:0] sel,
                                    input logic c, input logic r, input logic ng,
                                    input logic [2:0] st, input logic [7:0] att,
                                    input logic [7:0] leds);
        vec_t v;
        v.btn = btn; v.sel = sel; v.commit = c; v.retry = r; v.ng = ng;
        v.st = st; v.att = att; v.leds = leds;
        return v;
    endfunction

    function automatic exp_t mk_exp(input logic [2:0] st, input logic [7:0] att,
                                    input logic [7:0] leds);
        exp_t e;
        e.st = st; e.att = att; e.leds = leds;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_sb(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_applied++;
            n_miscompare++;
            $display("FAIL %s: got empty scoreboard, required an expected entry", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, " state"}, 32'(bus.state_o), 32'(e.st));
        chk({tag, " attempts"}, 32'(bus.attempts_o), 32'(e.att));
        chk({tag, " leds"}, 32'(bus.leds), 32'(e.leds));
        $display("%s: state=%0d attempts=%0d leds=%h", tag, bus.state_o, bus.attempts_o, bus.leds);
    endtask

    // Pulse the vector's inputs for one cycle, check, then idle one cycle to re-arm edges.
    task automatic apply_vec(input int idx);
        vec_t v;
        v = tbl[idx];
        bus.buttons   = v.btn;
        bus.digit_sel = v.sel;
        bus.commit    = v.commit;
        bus.retry     = v.retry;
        bus.new_game  = v.ng;
        sb.push_back(mk_exp(v.st, v.att, v.leds));
        @(negedge clock);
        check_sb($sformatf("vec%0d", idx));
        bus.buttons  = '0;
        bus.commit   = 1'b0;
        bus.retry    = 1'b0;
        bus.new_game = 1'b0;
        @(negedge clock);
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i < hi; i++) apply_vec(i);
    endtask

    // Watch one full scan and compare every digit's glyph against exp (digit k at [k*8+:8]).
    task automatic check_display(input string tag, input logic [31:0] exp);
        logic [3:0] seen;
        logic       found;
        seen = '0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clock);
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (bus.anodes == ~(4'b0001 << k)) begin
                    found = 1'b1;
                    if (!seen[k]) begin
                        seen[k] = 1'b1;
                        chk($sformatf("%s digit%0d glyph", tag, k), 32'(bus.cathods), 32'(exp[k*8 +: 8]));
                    end
                end
            end
            if (!found) begin
                n_applied++;
                n_miscompare++;
                $display("FAIL %s anodes: got %b, required exactly one low", tag, bus.anodes);
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (!seen[k]) begin
                n_applied++;
                n_miscompare++;
                $display("FAIL %s digit%0d scan: got never selected, required selected", tag, k);
            end
        end
    endtask

    initial begin
        logic [31:0] pl1_glyphs;
        logic [3:0]  exp_an;
        n_applied    = 0;
        n_miscompare = 0;
        reset         = 1'b1;
        bus.digit_sel = '0;
        bus.buttons   = '0;
        bus.commit    = 1'b0;
        bus.retry     = 1'b0;
        bus.new_game  = 1'b0;

        // Phase 1: secret {A,0,0,1}, low guess, high guess, edits back toward the secret.
        tbl.push_back(mk_vec(4'h1, 4'b0000, 0, 0, 0, S_SECRET, 8'd0, 8'h00));
        tbl.push_back(mk_vec(4'h5, 4'b0001, 0, 0, 0, S_SECRET, 8'd0, 8'h00));
        tbl.push_back(mk_vec(4'h5, 4'b0001, 0, 0, 0, S_SECRET, 8'd0, 8'h00));
        tbl.push_back(mk_vec(4'h1, 4'b1000, 0, 0, 0, S_SECRET, 8'd0, 8'h00));
        tbl.push_back(mk_vec(4'h0, 4'b0000, 1, 0, 0, S_P2,     8'd0, 8'h00));
        tbl.push_back(mk_vec(4'h1, 4'b0000, 0, 0, 0, S_GUESS,  8'd0, 8'h00));
        tbl.push_back(mk_vec(4'h9, 4'b0001, 0, 0, 0, S_GUESS,  8'd0, 8'h00));
        tbl.push_back(mk_vec(4'hF, 4'b0010, 0, 0, 0, S_GUESS,  8'd0, 8'h00));
        tbl.push_back(mk_vec(4'hF, 4'b0100, 0, 0, 0, S_GUESS,  8'd0, 8'h00));
        tbl.push_back(mk_vec(4'hF, 4'b1000, 0, 0, 0, S_GUESS,  8'd0, 8'h00));
        tbl.push_back(mk_vec(4'h0, 4'b0000, 1, 0, 0, S_LO,     8'd1, 8'h00));
        tbl.push_back(mk_vec(4'h0, 4'b0000, 0, 1, 0, S_GUESS,  8'd1, 8'h00));
        tbl.push_back(mk_vec(4'h1, 4'b0001, 0, 0, 0, S_GUESS,  8'd1, 8'h00));
        tbl.push_back(mk_vec(4'h0, 4'b0000, 1, 0, 0, S_HI,     8'd2, 8'h00));
        tbl.push_back(mk_vec(4'h0, 4'b0000, 0, 1, 0, S_GUESS,  8'd2, 8'h00));
        tbl.push_back(mk_vec(4'h1, 4'b0010, 0, 0, 0, S_GUESS,  8'd2, 8'h00));
        tbl.push_back(mk_vec(4'h1, 4'b0100, 0, 0, 0, S_GUESS,  8'd2, 8'h00));
        tbl.push_back(mk_vec(4'h2, 4'b1000, 0, 0, 0, S_GUESS,  8'd2, 8'h00));
        tbl.push_back(mk_vec(4'h1, 4'b0011, 0, 0, 0, S_GUESS,  8'd2, 8'h00));
        tbl.push_back(mk_vec(4'h3, 4'b0000, 0, 0, 0, S_GUESS,  8'd2, 8'h00));
        p1_end = tbl.size();
        // Phase 2: restart, secret {3,0,0,0}, two low guesses ahead of the lockout.
        tbl.push_back(mk_vec(4'h0, 4'b0000, 0, 0, 1, S_P1,     8'd0, 8'h00));
        tbl.push_back(mk_vec(4'h1, 4'b0000, 0, 0, 0, S_SECRET, 8'd0, 8'h00));
        tbl.push_back(mk_vec(4'h3, 4'b0001, 0, 0, 0, S_SECRET, 8'd0, 8'h00));
        tbl.push_back(mk_vec(4'h0, 4'b0000, 1, 0, 0, S_P2,     8'd0, 8'h00));
        tbl.push_back(mk_vec(4'h1, 4'b0000, 0, 0, 0, S_GUESS,  8'd0, 8'h00));
        tbl.push_back(mk_vec(4'h0, 4'b0000, 1, 0, 0, S_LO,     8'd1, 8'h00));
        tbl.push_back(mk_vec(4'h0, 4'b0000, 0, 1, 0, S_GUESS,  8'd1, 8'h00));
        tbl.push_back(mk_vec(4'h0, 4'b0000, 1, 0, 0, S_LO,     8'd2, 8'h00));
        tbl.push_back(mk_vec(4'h0, 4'b0000, 0, 1, 0, S_GUESS,  8'd2, 8'h00));
        p2_end = tbl.size();
        // Phase 3: after lockout, commit and new_game together, then re-enter secret entry.
        tbl.push_back(mk_vec(4'h1, 4'b0000, 0, 0, 0, S_GUESS,  8'd0, 8'h00));
        tbl.push_back(mk_vec(4'h0, 4'b0000, 1, 0, 0, S_LO,     8'd1, 8'h00));
        tbl.push_back(mk_vec(4'h0, 4'b0000, 0, 1, 0, S_GUESS,  8'd1, 8'h00));
        tbl.push_back(mk_vec(4'h0, 4'b0000, 1, 0, 1, S_P1,     8'd0, 8'h00));
        tbl.push_back(mk_vec(4'h1, 4'b0000, 0, 0, 0, S_SECRET, 8'd0, 8'h00));
        p3_end = tbl.size();

        repeat (3) @(negedge clock);
        reset = 1'b0;

        sb.push_back(mk_exp(S_P1, 8'd0, 8'h00));
        check_sb("reset");
        pl1_glyphs = {8'hF9, 8'hFF, 8'hC7, 8'h8C};
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clock);
            exp_an = ~(4'b0001 << (i / 3));
            chk($sformatf("scan%0d anodes", i), 32'(bus.anodes), 32'(exp_an));
            chk($sformatf("scan%0d glyph", i), 32'(bus.cathods), 32'(pl1_glyphs[(i/3)*8 +: 8]));
        end
        @(negedge clock);

        run_range(0, p1_end);
        check_display("guess_entry", 32'hF9C0C088);

        // Winning commit: leds start at FF and toggle every 4 cycles.
        bus.commit = 1'b1;
        for (int i = 0; i < 9; i++) begin
            sb.push_back(mk_exp(S_WIN, 8'd2, ((i / 4) % 2 == 0) ? 8'hFF : 8'h00));
            @(negedge clock);
            bus.commit = 1'b0;
            check_sb($sformatf("win%0d", i));
        end
        check_display("win", 32'hA4C0FFFF);

        run_range(p1_end, p2_end);

        // Third wrong guess locks; a commit mid-lock is ignored; P2 after 10 cycles.
        bus.commit = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i <= 9) sb.push_back(mk_exp(S_LOCK, 8'd3, 8'hAA));
            else        sb.push_back(mk_exp(S_P2, 8'd0, 8'h00));
            @(negedge clock);
            bus.commit = (i == 2);
            check_sb($sformatf("lock%0d", i));
        end
        bus.commit = 1'b0;
        @(negedge clock);

        run_range(p2_end, p3_end);

        // A button held for 20 cycles edits only once.
        bus.digit_sel = 4'b0001;
        bus.buttons   = 4'h2;
        repeat (20) @(negedge clock);
        sb.push_back(mk_exp(S_SECRET, 8'd0, 8'h00));
        check_sb("hold");
        bus.buttons = '0;
        check_display("hold", 32'hC0C0C0A4);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
        $finish;
    end
endmodule
